// File: rtl/decode_issue_stage.sv
// ID->EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use bubble
// insertion, EX hold/flush handling and a saturating count of load-use bubbles.
module decode_issue_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs,
    input  logic [ADDR_WIDTH-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [ADDR_WIDTH-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic [DATA_WIDTH-1:0] rf_data_1,
    input  logic [DATA_WIDTH-1:0] rf_data_2,
    input  logic                  exmem_reg_write,
    input  logic [ADDR_WIDTH-1:0] exmem_dest,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [ADDR_WIDTH-1:0] memwb_dest,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_dest,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic                  load_use;

    // Register 0 reads as zero even if a stage claims to write it.
    always_comb begin
        fwd_a = rf_data_1;
        if (id_rs == '0) begin
            fwd_a = '0;
        end else if (exmem_reg_write && (exmem_dest == id_rs)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_dest == id_rs)) begin
            fwd_a = memwb_result;
        end
    end

    always_comb begin
        fwd_b = rf_data_2;
        if (id_rt == '0) begin
            fwd_b = '0;
        end else if (exmem_reg_write && (exmem_dest == id_rt)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_dest == id_rt)) begin
            fwd_b = memwb_result;
        end
    end

    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                   ((id_uses_rs && (ex_dest == id_rs)) || (id_uses_rt && (ex_dest == id_rt)));
        id_stall = !reset && (load_use || ex_hold);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_dest      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= '0;
            stall_count  <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= '0;
        end else if (ex_hold) begin
            // EX is busy: every ex_* register keeps its value.
        end else if (load_use) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= '0;
            if (stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end else begin
            ex_valid     <= id_valid;
            ex_op_a      <= fwd_a;
            ex_op_b      <= fwd_b;
            ex_imm       <= id_imm;
            ex_dest      <= id_dest;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_ctrl      <= id_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: stimulus pushes expected EX state into a queue,
// an independent monitor pops and compares once per issued cycle.
module tb_decode_issue_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 8;
    // Narrow counter so saturation is reachable in a short run.
    localparam int unsigned NW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [AW-1:0] id_rs, id_rt, id_dest, exmem_dest, memwb_dest;
    logic [DW-1:0] id_imm, rf_data_1, rf_data_2, exmem_result, memwb_result;
    logic [CW-1:0] id_ctrl;
    logic          exmem_reg_write, memwb_reg_write, flush, ex_hold;
    logic          id_stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [AW-1:0] ex_dest;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] stall_count;

    typedef struct {
        logic          stall;
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [AW-1:0] dest;
        logic          rw;
        logic          mr;
        logic [CW-1:0] ctrl;
        logic [NW-1:0] cnt;
        logic          dchk;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    decode_issue_stage #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_dest(memwb_dest), .memwb_result(memwb_result), .flush(flush),
        .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic exp_full(input logic s, input logic v, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] imm,
                            input logic [AW-1:0] d, input logic rw, input logic mr,
                            input logic [CW-1:0] c, input logic [NW-1:0] n);
        exp_t e;
        e = '{stall: s, v: v, a: a, b: b, imm: imm, dest: d, rw: rw, mr: mr, ctrl: c,
              cnt: n, dchk: 1'b1};
        q.push_back(e);
    endtask

    task automatic exp_bub(input logic s, input logic [NW-1:0] n);
        exp_t e;
        e = '{stall: s, v: 1'b0, a: '0, b: '0, imm: '0, dest: '0, rw: 1'b0, mr: 1'b0,
              ctrl: '0, cnt: n, dchk: 1'b0};
        q.push_back(e);
    endtask

    task automatic drv_load(); // lw r8, 4(r1)
        id_valid = 1'b1; id_rs = 5'd1; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_dest = 5'd8; id_reg_write = 1'b1; id_mem_read = 1'b1; id_ctrl = 8'h11;
        id_imm = 32'h4; rf_data_1 = 32'h100; rf_data_2 = 32'h0;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    endtask

    task automatic drv_dep(); // add r9, r8, r1
        id_valid = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1; id_rt = 5'd1; id_uses_rt = 1'b1;
        id_dest = 5'd9; id_reg_write = 1'b1; id_mem_read = 1'b0; id_ctrl = 8'h22;
        id_imm = 32'h0; rf_data_1 = 32'hDEAD; rf_data_2 = 32'h100;
    endtask

    // Monitor: id_stall sampled just before the edge, registers just after it.
    initial begin
        exp_t e;
        logic s;
        forever begin
            @(negedge clock);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                s = id_stall;
                @(posedge clock);
                #1;
                chk("id_stall", {31'b0, s}, {31'b0, e.stall});
                chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.v});
                chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, e.rw});
                chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, e.mr});
                chk("ex_ctrl", {24'b0, ex_ctrl}, {24'b0, e.ctrl});
                chk("stall_count", {24'b0, stall_count}, {24'b0, e.cnt});
                if (e.dchk) begin
                    chk("ex_op_a", ex_op_a, e.a);
                    chk("ex_op_b", ex_op_b, e.b);
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_dest", {27'b0, ex_dest}, {27'b0, e.dest});
                end
            end
        end
    end

    initial begin
        logic [NW-1:0] cnt;
        reset = 1'b1; id_valid = 1'b1; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0;
        id_uses_rt = 1'b0; id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_imm = '0; id_ctrl = '0; rf_data_1 = '0; rf_data_2 = '0; exmem_reg_write = 1'b0;
        exmem_dest = '0; exmem_result = '0; memwb_reg_write = 1'b0; memwb_dest = '0;
        memwb_result = '0; flush = 1'b0; ex_hold = 1'b1;

        @(negedge clock);
        exp_full(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Forwarding priority on rs=5: EX/MEM, then MEM/WB, then register file.
        @(negedge clock);
        reset = 1'b0; ex_hold = 1'b0;
        id_valid = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1; id_rt = 5'd6; id_uses_rt = 1'b1;
        id_dest = 5'd7; id_reg_write = 1'b1; id_mem_read = 1'b0; id_imm = 32'h1234;
        id_ctrl = 8'hA5; rf_data_1 = 32'h33; rf_data_2 = 32'h44;
        exmem_reg_write = 1'b1; exmem_dest = 5'd5; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_dest = 5'd5; memwb_result = 32'h22;
        exp_full(0, 1, 32'h11, 32'h44, 32'h1234, 7, 1, 0, 8'hA5, 0);
        @(negedge clock);
        exmem_reg_write = 1'b0;
        exp_full(0, 1, 32'h22, 32'h44, 32'h1234, 7, 1, 0, 8'hA5, 0);
        @(negedge clock);
        memwb_reg_write = 1'b0; exmem_reg_write = 1'b1; exmem_dest = 5'd6;
        exmem_result = 32'h55;
        exp_full(0, 1, 32'h33, 32'h55, 32'h1234, 7, 1, 0, 8'hA5, 0);

        // r0 source reads zero even with stages "writing" r0.
        @(negedge clock);
        id_rs = 5'd0; exmem_dest = 5'd0; exmem_result = 32'hFFFF_FFFF;
        memwb_reg_write = 1'b1; memwb_dest = 5'd0; memwb_result = 32'hFFFF_FFFF;
        rf_data_1 = 32'h77;
        exp_full(0, 1, 32'h0, 32'h44, 32'h1234, 7, 1, 0, 8'hA5, 0);

        // Capture with id_valid=0 is a bubble.
        @(negedge clock);
        id_valid = 1'b0; id_ctrl = 8'hFF;
        exp_bub(0, 0);

        // Load then dependent add: one bubble, then MEM/WB forwarding of the load data.
        @(negedge clock);
        drv_load();
        exp_full(0, 1, 32'h100, 32'h0, 32'h4, 8, 1, 1, 8'h11, 0);
        @(negedge clock);
        drv_dep();
        exp_bub(1, 1);
        @(negedge clock);
        memwb_reg_write = 1'b1; memwb_dest = 5'd8; memwb_result = 32'hCAFE;
        exp_full(0, 1, 32'hCAFE, 32'h100, 32'h0, 9, 1, 0, 8'h22, 1);

        // Load into r0 never causes a load-use stall.
        @(negedge clock);
        drv_load(); id_dest = 5'd0; id_ctrl = 8'h33; id_imm = 32'h8;
        exp_full(0, 1, 32'h100, 32'h0, 32'h8, 0, 1, 1, 8'h33, 1);
        @(negedge clock);
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; id_dest = 5'd2; id_mem_read = 1'b0;
        id_ctrl = 8'h44; id_imm = 32'hC; rf_data_1 = 32'h5; rf_data_2 = 32'h6;
        exp_full(0, 1, 32'h0, 32'h0, 32'hC, 2, 1, 0, 8'h44, 1);

        // Hold for three cycles: EX frozen, IF/ID stalled; then flush during hold.
        @(negedge clock);
        ex_hold = 1'b1; id_rs = 5'd3; rf_data_1 = 32'h999; id_dest = 5'd4;
        id_ctrl = 8'h55; id_imm = 32'hF;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            exp_full(1, 1, 32'h0, 32'h0, 32'hC, 2, 1, 0, 8'h44, 1);
        end
        @(negedge clock);
        flush = 1'b1;
        exp_bub(1, 1);

        // Flush coinciding with load-use: stall asserted, no count.
        @(negedge clock);
        ex_hold = 1'b0; flush = 1'b0;
        drv_load();
        exp_full(0, 1, 32'h100, 32'h0, 32'h4, 8, 1, 1, 8'h11, 1);
        @(negedge clock);
        drv_dep(); id_rs = 5'd3; id_rt = 5'd8; flush = 1'b1;
        exp_bub(1, 1);

        // Matching rs that is not actually read does not stall.
        @(negedge clock);
        flush = 1'b0;
        drv_load();
        exp_full(0, 1, 32'h100, 32'h0, 32'h4, 8, 1, 1, 8'h11, 1);
        @(negedge clock);
        drv_dep(); id_uses_rs = 1'b0; id_rt = 5'd0; id_uses_rt = 1'b0; id_dest = 5'd10;
        id_ctrl = 8'h66; rf_data_1 = 32'h1;
        exp_full(0, 1, 32'h1, 32'h0, 32'h0, 10, 1, 0, 8'h66, 1);

        // Repeated load-use pairs drive the counter into saturation.
        cnt = 8'd1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            drv_load();
            exp_full(0, 1, 32'h100, 32'h0, 32'h4, 8, 1, 1, 8'h11, cnt);
            @(negedge clock);
            drv_dep();
            if (cnt != 8'hFF) cnt = cnt + 8'd1;
            exp_bub(1, cnt);
        end

        // Mid-stream reset with a valid load in EX, hold and a load-use pending.
        @(negedge clock);
        drv_load();
        exp_full(0, 1, 32'h100, 32'h0, 32'h4, 8, 1, 1, 8'h11, 8'hFF);
        @(negedge clock);
        drv_dep(); ex_hold = 1'b1; reset = 1'b1;
        exp_full(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0; ex_hold = 1'b0; id_valid = 1'b0;
        exp_bub(0, 0);

        repeat (4) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1);
        end
    end

endmodule
